// File: rtl/config_pkg.sv
// rtl/config_pkg.sv - shared state type and default sizes for config_loader
package config_pkg;

  localparam int DEFAULT_WORD_W    = 32;
  localparam int DEFAULT_CHAIN_LEN = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/config_loader.sv
// rtl/config_loader.sv - serialises host config words LSB-first into a config_cell chain
module config_loader #(
  parameter int WORD_W    = config_pkg::DEFAULT_WORD_W,
  parameter int CHAIN_LEN = config_pkg::DEFAULT_CHAIN_LEN
) (
  input  logic              config_clk,
  input  logic              config_reset,
  input  logic              start,
  input  logic              abort,
  input  logic              word_valid,
  input  logic [WORD_W-1:0] word_data,
  output logic              word_ready,
  output logic              config_out,
  output logic              config_en,
  output logic              busy,
  output logic              done
);
  import config_pkg::*;

  localparam int REM_W = $clog2(CHAIN_LEN + 1);
  localparam int WB_W  = $clog2(WORD_W + 1);
  localparam logic [REM_W-1:0] CHAIN_LEN_R = REM_W'(CHAIN_LEN);
  localparam logic [REM_W-1:0] REM_ONE     = REM_W'(1);
  localparam logic [WB_W-1:0]  WORD_W_B    = WB_W'(WORD_W);
  localparam logic [WB_W-1:0]  WB_ONE      = WB_W'(1);

  state_e             state_q, state_d;
  logic [REM_W-1:0]   remaining_q, remaining_d;
  logic [WB_W-1:0]    word_bits_q, word_bits_d;
  logic [WORD_W-1:0]  shift_reg_q, shift_reg_d;
  logic               word_ready_q, word_ready_d;
  logic               config_out_q, config_out_d;
  logic               config_en_q, config_en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    word_bits_d = word_bits_q;
    shift_reg_d = shift_reg_q;

    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          remaining_d = CHAIN_LEN_R;
          state_d     = FETCH;
        end
      end
      FETCH: begin
        if (abort) begin
          state_d = IDLE;
        end else if (word_valid) begin
          shift_reg_d = word_data;
          // A short final word only shifts the bits the chain still needs.
          if (int'(remaining_q) >= WORD_W) word_bits_d = WORD_W_B;
          else                             word_bits_d = WB_W'(remaining_q);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shift_reg_d = shift_reg_q >> 1;
        if (remaining_q != '0) remaining_d = remaining_q - REM_ONE;
        if (word_bits_q != '0) word_bits_d = word_bits_q - WB_ONE;
        if (abort)                     state_d = IDLE;
        else if (remaining_q <= REM_ONE) state_d = DONE;
        else if (word_bits_q <= WB_ONE)  state_d = FETCH;
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    word_ready_d = (state_d == FETCH);
    config_en_d  = (state_d == SHIFT);
    config_out_d = (state_d == SHIFT) & shift_reg_d[0];
    busy_d       = (state_d == FETCH) || (state_d == SHIFT);
    done_d       = (state_d == DONE);
  end

  always_ff @(posedge config_clk or negedge config_reset) begin
    if (!config_reset) begin
      state_q      <= IDLE;
      remaining_q  <= '0;
      word_bits_q  <= '0;
      shift_reg_q  <= '0;
      word_ready_q <= 1'b0;
      config_out_q <= 1'b0;
      config_en_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      word_bits_q  <= word_bits_d;
      shift_reg_q  <= shift_reg_d;
      word_ready_q <= word_ready_d;
      config_out_q <= config_out_d;
      config_en_q  <= config_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign word_ready = word_ready_q;
  assign config_out = config_out_q;
  assign config_en  = config_en_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
